// File: rtl/mult_cdb_buf.sv
// mult_cdb_buf: completion buffer between the pipelined multiplier and the
// CDB arbiter. Holds up to DEPTH retired result packets in FIFO order,
// requests the CDB for the oldest one, and stalls the multiplier when full.
// A squash flushes every buffered result.
//
// Optional feature: define MULT_CDB_BYPASS_EN to let a packet arriving at an
// empty buffer be offered to the CDB in the same cycle. If it is granted, it
// is never written. The default build has no bypass, so cdb_req/cdb_pkt come
// only from registered state and squash.
//
// PKT_W stands for the multiplier's FU_PACKET width. The instantiating level
// passes $bits(FU_PACKET); the packet is carried opaquely.
module mult_cdb_buf #(
   parameter int DEPTH = 4,
   parameter int PKT_W = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [PKT_W-1:0]         in_pkt,
   input  logic                     squash,
   input  logic                     cdb_gnt,
   output logic                     mult_stall,
   output logic                     cdb_req,
   output logic [PKT_W-1:0]         cdb_pkt,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PKT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             bypass_req;
   logic             bypass_take;

   // The stall comes only from the registered count, so neither in_valid nor
   // cdb_gnt has a combinational path to the multiplier's stall.
   assign full       = (count == FULL_CNT);
   assign empty      = (count == '0);
   assign mult_stall = full;

   // Request/packet presentation and the push/pop decisions for this cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      bypass_req = 1'b0;
`ifdef MULT_CDB_BYPASS_EN
      bypass_req = empty & in_valid & ~squash;
`endif
      bypass_take = bypass_req & cdb_gnt;

      cdb_req = (~empty & ~squash) | bypass_req;
      cdb_pkt = '0;
      if (~empty & ~squash) begin
         cdb_pkt = mem[head];
      end else if (bypass_req) begin
         cdb_pkt = in_pkt;
      end

      // A full buffer refuses the input even if it pops this cycle; the
      // multiplier holds the packet and it is taken once full drops.
      push = in_valid & ~full & ~squash & ~bypass_take;
      pop  = ~empty & ~squash & cdb_gnt;
   end

   // Packet storage: written at tail on each accepted push.
   always_ff @(posedge clock) begin
      // NOTE: the storage array is cleared on reset so a stale packet can
      // never be presented; it costs a reset fan-out on every entry.
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[tail] <= in_pkt;
      end
   end

   // Pointers and occupancy; squash empties the buffer and wins over push/pop.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset || squash) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: tb/tb_mult_cdb_buf.sv
// Self-checking bench for mult_cdb_buf (DEPTH=4, PKT_W=8). A queue-based
// model of the buffer is compared against the DUT on every cycle, and
// directed scenarios carry hand-computed literal expectations.
// Build with MULT_CDB_BYPASS_EN defined to exercise the bypass variant.
module tb_mult_cdb_buf;

   localparam int DEPTH = 4;
   localparam int PKT_W = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic [PKT_W-1:0] in_pkt = '0;
   logic             squash = 1'b0;
   logic             cdb_gnt = 1'b0;
   logic             mult_stall;
   logic             cdb_req;
   logic [PKT_W-1:0] cdb_pkt;
   logic [2:0]       count;

   int checks = 0;
   int errors = 0;

   logic [PKT_W-1:0] q[$];    // model contents, oldest first
   logic [PKT_W-1:0] got[$];  // packets the DUT delivered on a grant
   bit               started = 1'b0;

   mult_cdb_buf #(.DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_pkt     (in_pkt),
      .squash     (squash),
      .cdb_gnt    (cdb_gnt),
      .mult_stall (mult_stall),
      .cdb_req    (cdb_req),
      .cdb_pkt    (cdb_pkt),
      .count      (count)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=done");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare the DUT against the queue model for the current cycle, then
   // advance the model to what the buffer must hold after the next edge.
   task automatic model_cycle();
      int  n;
      bit  byp;
      bit  exp_req;
      logic [PKT_W-1:0] exp_pkt;
      n = q.size();
      byp = 1'b0;
`ifdef MULT_CDB_BYPASS_EN
      byp = (n == 0) && in_valid && !squash;
`endif
      exp_req = ((n != 0) && !squash) || byp;
      exp_pkt = '0;
      if (exp_req) exp_pkt = (n != 0) ? q[0] : in_pkt;

      check("model count", 32'(count), 32'(n));
      check("model mult_stall", 32'(mult_stall), 32'(n == DEPTH));
      check("model cdb_req", 32'(cdb_req), 32'(exp_req));
      check("model cdb_pkt", 32'(cdb_pkt), 32'(exp_pkt));

      if (!reset && exp_req && cdb_gnt) got.push_back(cdb_pkt);

      if (reset || squash) begin
         q.delete();
      end else begin
         if (n != 0 && cdb_gnt) void'(q.pop_front());
         if (in_valid && n != DEPTH && !(byp && cdb_gnt)) q.push_back(in_pkt);
      end
   endtask

   // One clock cycle: drive inputs just after the edge, sample at the falling edge.
   task automatic step(input logic v, input logic [PKT_W-1:0] p, input logic sq,
                       input logic g, input logic r);
      @(posedge clock);
      #1;
      in_valid = v;
      in_pkt   = p;
      squash   = sq;
      cdb_gnt  = g;
      reset    = r;
      @(negedge clock);
      if (started) model_cycle();
   endtask

   initial begin
      int base;

      // Reset
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      started = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("reset count", 32'(count), 32'd0);
      check("reset cdb_req", 32'(cdb_req), 32'd0);
      check("reset cdb_pkt", 32'(cdb_pkt), 32'd0);
      check("reset mult_stall", 32'(mult_stall), 32'd0);

      // Single packet with grant always high
      step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
`ifdef MULT_CDB_BYPASS_EN
      check("single bypass req", 32'(cdb_req), 32'd1);
      check("single bypass pkt", 32'(cdb_pkt), 32'hA5);
`else
      check("single cycle1 req", 32'(cdb_req), 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("single cycle2 req", 32'(cdb_req), 32'd1);
      check("single cycle2 pkt", 32'(cdb_pkt), 32'hA5);
`endif
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("single drained count", 32'(count), 32'd0);
      check("single drained req", 32'(cdb_req), 32'd0);

      // Fill to full, hold packet 5 while stalled, grant once
      base = got.size();
      for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
      check("fill count", 32'(count), 32'd4);
      check("fill stall", 32'(mult_stall), 32'd1);
      step(1'b1, 8'h05, 1'b0, 1'b1, 1'b0);
      check("first pop pkt", 32'(cdb_pkt), 32'h01);
      check("stall during pop", 32'(mult_stall), 32'd1);
      step(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
      check("stall released", 32'(mult_stall), 32'd0);
      check("count after pop", 32'(count), 32'd3);
      for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("fill delivered n", 32'(got.size() - base), 32'd5);
      for (int k = 0; k < 5; k++) begin
         if (base + k < got.size()) check("fill order", 32'(got[base+k]), 32'(k + 1));
      end

      // Simultaneous push and pop at count 2, wrapping the pointers
      base = got.size();
      step(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 8'(8'h23 + k), 1'b0, 1'b1, 1'b0);
         check("pushpop count", 32'(count), 32'd2);
      end
      for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("pushpop delivered n", 32'(got.size() - base), 32'd8);
      for (int k = 0; k < 8; k++) begin
         if (base + k < got.size()) check("pushpop order", 32'(got[base+k]), 32'(8'h21 + k));
      end

      // Squash with input and grant active
      base = got.size();
      for (int k = 1; k <= 3; k++) step(1'b1, 8'(8'h30 + k), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
      check("squash req", 32'(cdb_req), 32'd0);
      check("squash count same cycle", 32'(count), 32'd3);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("post squash count", 32'(count), 32'd0);
      check("post squash pkt", 32'(cdb_pkt), 32'd0);
      check("post squash req", 32'(cdb_req), 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("squash nothing delivered", 32'(got.size() - base), 32'd0);

      // Reset in the middle of operation
      for (int k = 1; k <= 3; k++) step(1'b1, 8'(8'h50 + k), 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("pre reset count", 32'(count), 32'd3);
      check("pre reset stall", 32'(mult_stall), 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("mid reset count", 32'(count), 32'd0);
      check("mid reset req", 32'(cdb_req), 32'd0);
      check("mid reset stall", 32'(mult_stall), 32'd0);
      base = got.size();
      step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("after reset count", 32'(count), 32'd0);
      check("after reset delivered n", 32'(got.size() - base), 32'd1);
      if (got.size() > base) check("after reset pkt", 32'(got[base]), 32'h11);

`ifdef MULT_CDB_BYPASS_EN
      // Bypass: granted packet is consumed, ungranted one is written
      step(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
      check("bypass req", 32'(cdb_req), 32'd1);
      check("bypass pkt", 32'(cdb_pkt), 32'h3C);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("bypass consumed count", 32'(count), 32'd0);
      step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
      check("bypass nognt req", 32'(cdb_req), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("bypass written count", 32'(count), 32'd1);
      check("bypass written pkt", 32'(cdb_pkt), 32'h3C);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("bypass drained count", 32'(count), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_cdb_buf.md
# mult_cdb_buf

Completion buffer between the pipelined multiplier's output and the common data bus (CDB) arbiter. It captures each result packet the multiplier retires, holds up to DEPTH of them in FIFO order, and requests the CDB for the oldest one. It back-pressures the multiplier through the multiplier's global `stall` input whenever it has no free entry. A squash input discards all buffered results on a branch mispredict.

## Interface
- `DEPTH`, default 4 — buffer entries; power of two, ≥2.
- `PKT_W`, default $bits(FU_PACKET) — packet width carried opaquely.
- `clock`  in  1  — clock; all state updates on posedge.
- `reset`  in  1  — synchronous, active-high.
- `in_valid`  in  1  — multiplier `data_ready`.
- `in_pkt`  in  PKT_W  — multiplier `fu_pack`.
- `squash`  in  1  — mispredict flush; synchronous.
- `cdb_gnt`  in  1  — arbiter grant for this cycle's request.
- `mult_stall`  out  1  — drives the multiplier `stall`.
- `cdb_req`  out  1  — a packet is presented on `cdb_pkt`.
- `cdb_pkt`  out  PKT_W  — oldest packet; 0 when `cdb_req`=0.
- `count`  out  $clog2(DEPTH)+1  — occupied entries.

## Operation
- Storage: DEPTH×PKT_W array, head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; `count` register 0..DEPTH.
- `full` = (`count`==DEPTH); `mult_stall` = `full`, combinational from `count` only. It never depends on `cdb_gnt`.
- push = `in_valid` & !`full` & !`squash`. Write at tail, then tail+1.
  - While stalled, the multiplier freezes and holds `in_valid`/`in_pkt` steady.
  - The same packet is pushed exactly once: on the first cycle `full` is low.
- pop = `cdb_req` & `cdb_gnt` & !`squash`. Head advances.
- Same-cycle push and pop when not full: `count` unchanged, both pointers advance.
- At `full`: a push is not accepted even if a pop occurs that cycle. `mult_stall` drops the following cycle.
- `cdb_req` = (`count`!=0) & !`squash` (plus the bypass term, see Configuration). `cdb_pkt` = entry[head] when requested, else 0.
- `cdb_gnt` without `cdb_req` is ignored.
- `squash`:
  - next cycle: `count`=0, head=tail=0.
  - that cycle: input dropped, `cdb_req`=0.
  - squash has priority over push and pop.
- `reset`: `count`=0, head=tail=0, storage cleared to 0. Outputs next cycle: `cdb_req`=0, `cdb_pkt`=0, `mult_stall`=0.

## Timing
- Non-bypass latency: packet accepted at edge of cycle N → `cdb_req` high in cycle N+1.
- Throughput: one push and one pop per cycle.
- Grant in cycle N removes the entry at the edge ending N. The next entry, if any, is presented in N+1.
- Stall assertion: the push filling the last entry makes `mult_stall`=1 in the next cycle.
- Stall release: the first pop from full makes `mult_stall`=0 in the cycle after the pop.
- No combinational path from `in_valid` or `cdb_gnt` to `mult_stall`.

## Configuration
- `MULT_CDB_BYPASS_EN` defined:
  - When `count`==0 and `in_valid` & !`squash`, `cdb_req`=1 and `cdb_pkt`=`in_pkt` in the same cycle (zero latency).
  - If `cdb_gnt` is also high, the packet is consumed and not written.
  - Otherwise it is written normally.
  - This adds a combinational path `in_valid`→`cdb_req`.
- Undefined: no bypass; minimum latency is 1 cycle as above. `cdb_req`/`cdb_pkt` are functions of registered state and `squash` only.

## Test plan
- Single packet, no bypass: `in_valid`=1 with `in_pkt`=0xA5 in cycle 1, `cdb_gnt`=1 always → `cdb_req`=1 with `cdb_pkt`=0xA5 in cycle 2; `count` returns to 0 in cycle 3.
- Fill/stall: DEPTH=4, 4 back-to-back packets 1..4 with `cdb_gnt`=0 → `count`=4, `mult_stall`=1. Hold packet 5 on input, grant once → order 1,2,3,4,5 delivered, packet 5 exactly once, `mult_stall` low one cycle after the first pop.
- Simultaneous push/pop: `count`=2, `in_valid`=1, `cdb_gnt`=1 for 6 cycles → `count` stays 2, FIFO order preserved, pointers wrap past 3→0 with no lost packet.
- Squash: `count`=3, `squash`=1 with `in_valid`=1 and `cdb_gnt`=1 → `cdb_req`=0 that cycle; next cycle `count`=0, `cdb_pkt`=0; the input packet never appears.
- Reset mid-operation: `count`=3, `mult_stall`=0, assert `reset` one cycle → `count`=0, `cdb_req`=0, `mult_stall`=0; the next push of 0x11 appears alone.
- Bypass (`MULT_CDB_BYPASS_EN`): empty buffer, `in_pkt`=0x3C with `cdb_gnt`=1 → `cdb_req`=1, `cdb_pkt`=0x3C in the same cycle, `count` stays 0. With `cdb_gnt`=0 instead → `count`=1 next cycle.
